// File: rtl/decoder_scan_sequencer.sv
// Cycling index/enable source for one-hot decoders: programmable dwell, last index, graceful stop.
// Define DECODER_SCAN_BLANK_EN to insert one blanking cycle between indices.
module decoder_scan_sequencer #(
  parameter int unsigned SEL_WIDTH   = 3,
  parameter int unsigned DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [SEL_WIDTH-1:0]   last,
  output logic [SEL_WIDTH-1:0]   sel,
  output logic                   sel_en,
  output logic                   busy,
  output logic                   wrap
);

  typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   wrap_q, wrap_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [SEL_WIDTH-1:0]   last_q, last_d;
  logic                   stop_pend_q, stop_pend_d;

  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic [SEL_WIDTH-1:0]   sel_next;

  assign dwell_eff = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
  // Wrap is an explicit compare so last = all-ones never relies on overflow.
  assign sel_next  = (sel_q == last_q) ? '0 : sel_q + SEL_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_d        = en_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    last_d      = last_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dwell_d     = dwell_eff;
          last_d      = last;
          state_d     = StDrive;
          sel_d       = '0;
          en_d        = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = dwell_eff - DWELL_WIDTH'(1);
          stop_pend_d = 1'b0;
        end
      end
      StDrive: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (stop_pend_q || stop) begin
          state_d     = StIdle;
          sel_d       = '0;
          en_d        = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
        end else begin
          sel_d = sel_next;
          cnt_d = dwell_q - DWELL_WIDTH'(1);
`ifdef DECODER_SCAN_BLANK_EN
          state_d = StBlank;
          en_d    = 1'b0;
`endif
        end
      end
`ifdef DECODER_SCAN_BLANK_EN
      StBlank: begin
        // A stop here still lets the already-presented index run its full dwell.
        if (stop) stop_pend_d = 1'b1;
        state_d = StDrive;
        en_d    = 1'b1;
      end
`endif
      default: begin
        state_d = StIdle;
        sel_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Registered wrap: flag the upcoming final cycle of the last index.
    wrap_d = (state_d == StDrive) && (cnt_d == '0) && (sel_d == last_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      dwell_q     <= DWELL_WIDTH'(1);
      last_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      last_q      <= last_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign sel    = sel_q;
  assign sel_en = en_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: directed vector tables plus a randomized run against
// an arithmetic schedule model (index = elapsed / period mod (last+1)).
module tb_decoder_scan_sequencer;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int Blank = 1;
`else
  localparam int Blank = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [2:0] last = 3'd0;
  logic [2:0] sel;
  logic       sel_en;
  logic       busy;
  logic       wrap;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decoder_scan_sequencer #(
    .SEL_WIDTH  (3),
    .DWELL_WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .dwell (dwell),
    .last  (last),
    .sel   (sel),
    .sel_en(sel_en),
    .busy  (busy),
    .wrap  (wrap)
  );

  typedef struct {
    logic r;
    logic st;
    logic sp;
    int   dw;
    int   la;
    int   e_sel;
    logic e_en;
    logic e_busy;
    logic e_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic st, input logic sp, input int dw, input int la,
                     input int es, input logic ee, input logic eb, input logic ew);
    vec_t v;
    v.r = r; v.st = st; v.sp = sp; v.dw = dw; v.la = la;
    v.e_sel = es; v.e_en = ee; v.e_busy = eb; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Schedule model state
  bit m_active;
  int m_n;
  int m_d;
  int m_l;
  bit m_stopreq;

  initial begin
    // Reset held low for two cycles: outputs must be all zero.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifndef DECODER_SCAN_BLANK_EN
    // dwell=3, last=2; stop at c10 ends after that dwell
    add(1, 1, 0, 3, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 3, 2, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 3, 2, 1, 1, 1, 0);
    add(1, 0, 0, 3, 2, 2, 1, 1, 0);
    add(1, 0, 0, 3, 2, 2, 1, 1, 0);
    add(1, 0, 0, 3, 2, 2, 1, 1, 1);
    add(1, 0, 1, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 0, 0, 0);
    // graceful stop, start during DRIVE ignored
    add(1, 1, 0, 4, 3, 0, 0, 0, 0);
    add(1, 0, 0, 4, 3, 0, 1, 1, 0);
    add(1, 0, 1, 4, 3, 0, 1, 1, 0);
    add(1, 1, 0, 4, 3, 0, 1, 1, 0);
    add(1, 0, 0, 4, 3, 0, 1, 1, 0);
    add(1, 0, 0, 4, 3, 0, 0, 0, 0);
    // dwell=0 acts as 1, last=7 wraps explicitly; dwell change mid-scan ignored
    add(1, 1, 0, 0, 7, 0, 0, 0, 0);
    add(1, 0, 0, 0, 7, 0, 1, 1, 0);
    for (int i = 1; i < 7; i++) add(1, 0, 0, 5, 7, i, 1, 1, 0);
    add(1, 0, 0, 5, 7, 7, 1, 1, 1);
    add(1, 0, 1, 5, 7, 0, 1, 1, 0);
    add(1, 0, 0, 5, 7, 0, 0, 0, 0);
    // reset mid-scan then restart
    add(1, 1, 0, 3, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 1, 1, 1, 0);
    add(1, 0, 0, 3, 2, 1, 1, 1, 0);
    add(0, 0, 0, 3, 2, 1, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 0, 0, 0);
    add(1, 1, 0, 3, 2, 0, 0, 0, 0);
    add(1, 0, 1, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 1, 1, 0);
    add(1, 0, 0, 3, 2, 0, 0, 0, 0);
    // last=0 wraps at every expiry
    add(1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 1, 1);
    add(1, 0, 1, 1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
`else
    // dwell=2, last=1 with blanking; stop in BLANK completes the next index
    add(1, 1, 0, 2, 1, 0, 0, 0, 0);
    add(1, 0, 0, 2, 1, 0, 1, 1, 0);
    add(1, 0, 0, 2, 1, 0, 1, 1, 0);
    add(1, 0, 0, 2, 1, 1, 0, 1, 0);
    add(1, 0, 0, 2, 1, 1, 1, 1, 0);
    add(1, 0, 0, 2, 1, 1, 1, 1, 1);
    add(1, 0, 1, 2, 1, 0, 0, 1, 0);
    add(1, 0, 0, 2, 1, 0, 1, 1, 0);
    add(1, 0, 0, 2, 1, 0, 1, 1, 0);
    add(1, 1, 0, 2, 1, 0, 0, 0, 0);
    // stop at expiry skips BLANK
    add(1, 0, 0, 2, 1, 0, 1, 1, 0);
    add(1, 0, 1, 2, 1, 0, 1, 1, 0);
    add(1, 0, 0, 2, 1, 0, 0, 0, 0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("vec%0d sel", i), int'(sel), vecs[i].e_sel);
      check($sformatf("vec%0d sel_en", i), int'(sel_en), int'(vecs[i].e_en));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d wrap", i), int'(wrap), int'(vecs[i].e_wrap));
      rst_n = vecs[i].r;
      start = vecs[i].st;
      stop  = vecs[i].sp;
      dwell = 8'(vecs[i].dw);
      last  = 3'(vecs[i].la);
    end

    // Randomized run against the schedule model
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    m_active = 1'b0; m_n = 0; m_d = 1; m_l = 0; m_stopreq = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int p, idx, ph, e_sel;
      bit e_en, e_wrap;
      @(negedge clk);
      e_sel = 0; e_en = 0; e_wrap = 0;
      if (m_active) begin
        p   = m_d + Blank;
        idx = (m_n / p) % (m_l + 1);
        ph  = m_n % p;
        if (ph < m_d) begin
          e_sel  = idx;
          e_en   = 1;
          e_wrap = (ph == m_d - 1) && (idx == m_l);
        end else begin
          e_sel = (idx == m_l) ? 0 : idx + 1;
        end
      end
      check($sformatf("rnd%0d sel", cyc), int'(sel), e_sel);
      check($sformatf("rnd%0d sel_en", cyc), int'(sel_en), int'(e_en));
      check($sformatf("rnd%0d busy", cyc), int'(busy), int'(m_active));
      check($sformatf("rnd%0d wrap", cyc), int'(wrap), int'(e_wrap));
      if (sel_en) check($sformatf("rnd%0d sel_le_last", cyc), int'(int'(sel) <= m_l), 1);

      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      dwell = 8'($urandom_range(0, 4));
      last  = 3'($urandom_range(0, 7));

      if (!rst_n) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active  = 1'b1;
          m_n       = 0;
          m_d       = (dwell == 0) ? 1 : int'(dwell);
          m_l       = int'(last);
          m_stopreq = 1'b0;
        end
      end else begin
        if (stop) m_stopreq = 1'b1;
        if (((m_n % (m_d + Blank)) == m_d - 1) && m_stopreq) m_active = 1'b0;
        else m_n++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
